// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus between the memory-access stage and data memory.
interface mem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues data loads/stores over a req/ack bus and
// registers execute results into the MEM/WB register feeding writeback.
module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_in,
    input  logic [3:0]   rd_num_in,
    input  logic [31:0]  md_in,
    input  logic [31:0]  result_in,
    input  logic [31:0]  cpsr_in,
    input  logic         taken_in,
    input  logic         is_alu_op_in,
    input  logic         is_cmp_op_in,
    input  logic         is_jmp_op_in,
    input  logic         is_ld_op_in,
    input  logic         is_str_op_in,
    output logic         stall,
    mem_access_if.master dmem,
    output logic         valid_out,
    output logic [3:0]   rd_num_passthrough,
    output logic [31:0]  md_passthrough,
    output logic [31:0]  result,
    output logic [31:0]  cpsr_passthrough,
    output logic [31:0]  dmem_val_passthrough,
    output logic         taken,
    output logic         is_alu_op_passthrough,
    output logic         is_cmp_op_passthrough,
    output logic         is_jmp_op_passthrough,
    output logic         is_ld_op_passthrough,
    output logic         mem_fault
);
    localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state_r, state_nxt;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;
    logic             req_r, req_nxt, we_r, we_nxt;
    logic [31:0]      addr_r, addr_nxt, wdata_r, wdata_nxt;
    logic             valid_r, valid_nxt, taken_r, taken_nxt, fault_r, fault_nxt;
    logic [3:0]       rd_r, rd_nxt;
    logic [31:0]      md_r, md_nxt, res_r, res_nxt, cpsr_r, cpsr_nxt, dval_r, dval_nxt;
    // ops vectors are ordered {ld, jmp, cmp, alu}
    logic [3:0]       ops_r, ops_nxt;
    logic [3:0]       ops_in_s;
    logic             mem_op_s, aligned_s, timeout_hit_s;

    assign ops_in_s      = {is_ld_op_in, is_jmp_op_in, is_cmp_op_in, is_alu_op_in};
    assign mem_op_s      = valid_in & (is_ld_op_in | is_str_op_in);
    assign aligned_s     = (result_in[1:0] == 2'b00);
    assign timeout_hit_s = (TIMEOUT != 32'sd0) && (cnt_r == CNT_LAST) && !dmem.dmem_ack;

    // Next-state, stall and next MEM/WB / bus register values
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        req_nxt   = req_r;
        we_nxt    = we_r;
        addr_nxt  = addr_r;
        wdata_nxt = wdata_r;
        valid_nxt = valid_r;
        rd_nxt    = rd_r;
        md_nxt    = md_r;
        res_nxt   = res_r;
        cpsr_nxt  = cpsr_r;
        taken_nxt = taken_r;
        dval_nxt  = dval_r;
        ops_nxt   = ops_r;
        fault_nxt = 1'b0;
        stall     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                stall = mem_op_s & aligned_s;
                if (!valid_in) begin
                    valid_nxt = 1'b0;
                    ops_nxt   = 4'b0000;
                end else if (mem_op_s && aligned_s) begin
                    req_nxt   = 1'b1;
                    we_nxt    = is_str_op_in;
                    addr_nxt  = result_in;
                    wdata_nxt = md_in;
                    cnt_nxt   = CNT_ZERO;
                    valid_nxt = 1'b0;
                    ops_nxt   = 4'b0000;
                    state_nxt = ST_WAIT;
                end else begin
                    // misaligned memory ops retire as a valid bubble so writeback does nothing
                    fault_nxt = mem_op_s;
                    valid_nxt = 1'b1;
                    ops_nxt   = mem_op_s ? 4'b0000 : ops_in_s;
                    rd_nxt    = rd_num_in;
                    md_nxt    = md_in;
                    res_nxt   = result_in;
                    cpsr_nxt  = cpsr_in;
                    taken_nxt = taken_in;
                end
            end
            ST_WAIT: begin
                stall = ~dmem.dmem_ack & ~timeout_hit_s;
                if (dmem.dmem_ack || timeout_hit_s) begin
                    // ack wins over a simultaneous timeout because timeout_hit_s excludes ack
                    req_nxt   = 1'b0;
                    fault_nxt = timeout_hit_s;
                    valid_nxt = 1'b1;
                    ops_nxt   = dmem.dmem_ack ? ops_in_s : 4'b0000;
                    rd_nxt    = rd_num_in;
                    md_nxt    = md_in;
                    res_nxt   = result_in;
                    cpsr_nxt  = cpsr_in;
                    taken_nxt = taken_in;
                    dval_nxt  = (dmem.dmem_ack && !we_r) ? dmem.dmem_rdata : dval_r;
                    state_nxt = ST_IDLE;
                end else if (cnt_r != CNT_MAX) begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end else begin
                    cnt_nxt = cnt_r;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, memory bus and MEM/WB registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            valid_r <= 1'b0;
            rd_r    <= 4'h0;
            md_r    <= 32'h0000_0000;
            res_r   <= 32'h0000_0000;
            cpsr_r  <= 32'h0000_0000;
            taken_r <= 1'b0;
            dval_r  <= 32'h0000_0000;
            ops_r   <= 4'b0000;
            fault_r <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            req_r   <= req_nxt;
            we_r    <= we_nxt;
            addr_r  <= addr_nxt;
            wdata_r <= wdata_nxt;
            valid_r <= valid_nxt;
            rd_r    <= rd_nxt;
            md_r    <= md_nxt;
            res_r   <= res_nxt;
            cpsr_r  <= cpsr_nxt;
            taken_r <= taken_nxt;
            dval_r  <= dval_nxt;
            ops_r   <= ops_nxt;
            fault_r <= fault_nxt;
        end
    end

    assign dmem.dmem_req         = req_r;
    assign dmem.dmem_we          = we_r;
    assign dmem.dmem_addr        = addr_r;
    assign dmem.dmem_wdata       = wdata_r;
    assign valid_out             = valid_r;
    assign rd_num_passthrough    = rd_r;
    assign md_passthrough        = md_r;
    assign result                = res_r;
    assign cpsr_passthrough      = cpsr_r;
    assign dmem_val_passthrough  = dval_r;
    assign taken                 = taken_r;
    assign is_alu_op_passthrough = ops_r[0];
    assign is_cmp_op_passthrough = ops_r[1];
    assign is_jmp_op_passthrough = ops_r[2];
    assign is_ld_op_passthrough  = ops_r[3];
    assign mem_fault             = fault_r;
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access pipeline stage that sits between execute and writeback.
- Performs data-memory loads and stores over a req/ack handshake.
- Registers all execute results into a MEM/WB pipeline register, whose outputs drive writeback directly.
- Stalls upstream while a memory transaction is outstanding. Flags misaligned accesses and access timeouts.

Parameters:
- TIMEOUT, 16, number of WAIT cycles without dmem_ack before the access is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  execute presents a valid instruction
- rd_num_in  in  4  destination register
- md_in  in  32  store data / branch target
- result_in  in  32  ALU result; the effective address for ld/str
- cpsr_in  in  32  NZCV from execute
- taken_in  in  1  branch taken
- is_alu_op_in, is_cmp_op_in, is_jmp_op_in, is_ld_op_in, is_str_op_in  in  1 each  opcode class, one-hot or all zero
- stall  out  1  upstream must hold its inputs while high
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  word address (byte address, bits [1:0] = 0)
- dmem_wdata  out  32  store data
- dmem_rdata  in  32  load data, valid with dmem_ack
- dmem_ack  in  1  transaction complete
- valid_out  out  1  MEM/WB register holds a valid instruction
- rd_num_passthrough  out  4  to writeback
- md_passthrough  out  32  to writeback
- result  out  32  to writeback
- cpsr_passthrough  out  32  to writeback
- dmem_val_passthrough  out  32  captured load data
- taken  out  1  to writeback
- is_alu_op_passthrough, is_cmp_op_passthrough, is_jmp_op_passthrough, is_ld_op_passthrough  out  1 each  to writeback
- mem_fault  out  1  one-cycle pulse on misalignment or timeout

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, timeout counter = 0.
  - Every output register is 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, valid_out, all passthroughs, all is_*_passthrough, mem_fault.
  - Reset mid-transaction abandons the access; dmem_req drops immediately.
- mem_op = valid_in & (is_ld_op_in | is_str_op_in).
- aligned = (result_in[1:0] == 0).
- stall (combinational) = (state == IDLE & mem_op & aligned) | (state == WAIT & ~dmem_ack & ~timeout_hit).
- IDLE, non-memory op or aligned==0 (valid_in=1):
  - At the edge, the MEM/WB register loads all inputs; valid_out = 1.
  - Latency: 1 cycle.
- IDLE, valid_in=0:
  - At the edge, a bubble loads: valid_out = 0 and all is_*_passthrough = 0. The data passthroughs may hold.
- IDLE, mem_op & aligned==0:
  - No request is issued; mem_fault pulses for 1 cycle.
  - A bubble loads: valid_out = 1, all is_* = 0, so writeback writes nothing.
- IDLE, mem_op & aligned:
  - At the edge: dmem_req = 1, dmem_we = is_str_op_in, dmem_addr = result_in, dmem_wdata = md_in, counter = 0; go to WAIT.
  - The MEM/WB register loads a bubble.
- WAIT:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable.
  - dmem_ack is sampled only in WAIT; ack in IDLE is ignored.
  - Ack is legal in the first WAIT cycle.
- WAIT, dmem_ack = 1:
  - stall = 0, so upstream advances.
  - At the edge the MEM/WB register loads the (held) inputs; dmem_val_passthrough = dmem_rdata for loads; dmem_req = 0; go to IDLE.
  - Stores output valid_out = 1 with all is_* = 0.
  - Minimum memory-op latency is 2 cycles: input to valid_out.
- WAIT, no ack:
  - counter increments.
  - timeout_hit = (TIMEOUT != 0) & (counter == TIMEOUT-1) & ~dmem_ack.
  - On timeout_hit, at the edge: dmem_req = 0, mem_fault pulses, the bubble-with-valid loads (all is_* = 0), go to IDLE.
- Ack and timeout in the same cycle: ack wins; the access completes normally.
- The counter saturates and never wraps.
- Inputs are not re-sampled in WAIT: upstream is stalled, so the held values are used.
- Only one transaction is ever outstanding.

Test Plan:
- ALU op (valid_in=1, is_alu=1, rd=3, result_in=0x1234) → next cycle valid_out=1, rd_num_passthrough=3, result=0x1234, is_alu_op_passthrough=1, stall never high.
- Load from 0x100, ack 3 cycles after req with rdata=0xDEADBEEF → stall high 4 cycles, dmem_addr=0x100 and dmem_we=0 stable throughout, then dmem_val_passthrough=0xDEADBEEF, is_ld_op_passthrough=1.
- Store to 0x200, md_in=0xCAFE, ack in first WAIT cycle → dmem_we=1, dmem_wdata=0xCAFE, valid_out=1 two cycles after input, all is_*=0.
- Load from 0x102 → no dmem_req, mem_fault pulses once, all is_*=0, stall stays 0.
- Load with ack never asserted, TIMEOUT=16 → dmem_req drops after 16 WAIT cycles, mem_fault pulses, state returns to IDLE, next ALU op passes normally; repeat with ack exactly on the 16th WAIT cycle → normal completion, no fault.
- rst_n low mid-WAIT → dmem_req, valid_out and mem_fault all 0 immediately; after release, ack arriving late is ignored.
